// File: rtl/dcache_pkg.sv
// Shared types and helpers for the 2-way set-associative write-back data cache.
// Holds the controller state encoding, the derived address-field widths and the byte merge.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        REFILL
    } state_t;

    function automatic int unsigned calc_off_w(input int unsigned line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int unsigned calc_idx_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned calc_tag_w(input int unsigned addr_w,
                                               input int unsigned line_w,
                                               input int unsigned sets);
        return addr_w - calc_idx_w(sets) - calc_off_w(line_w);
    endfunction

    // Each byte lane is taken from new_word when its strobe is set, else kept from old_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] mask;
        for (int unsigned b = 0; b < 4; b++) begin
            mask[b*8 +: 8] = {8{be[b]}};
        end
        return (old_word & ~mask) | (new_word & mask);
    endfunction

endpackage

// File: rtl/dcache_2way_top_if.sv
// CPU data port and line-wide memory bus of the data cache, bundled together.
// The cache connects through the slave modport; the CPU/memory environment uses master.
interface dcache_2way_top_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
);
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_data_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [31:0]       p1_data_i;
    logic [3:0]        p1_be_i;
    logic [ADDR_W-1:0] p1_addr_i;
    logic              p1_MemRead_i;
    logic              p1_MemWrite_i;
    logic [31:0]       p1_data_o;
    logic              p1_stall_o;

    modport slave (
        input  mem_data_i, mem_ack_i,
        input  p1_data_i, p1_be_i, p1_addr_i, p1_MemRead_i, p1_MemWrite_i,
        output mem_data_o, mem_addr_o, mem_enable_o, mem_write_o,
        output p1_data_o, p1_stall_o
    );

    modport master (
        output mem_data_i, mem_ack_i,
        output p1_data_i, p1_be_i, p1_addr_i, p1_MemRead_i, p1_MemWrite_i,
        input  mem_data_o, mem_addr_o, mem_enable_o, mem_write_o,
        input  p1_data_o, p1_stall_o
    );
endinterface

// File: rtl/dcache_way_array.sv
// One way of the data cache: tag, valid, dirty and line storage indexed by set.
// Reads are combinational; a line write (refill) takes priority over a strobed word write.
module dcache_way_array
    import dcache_pkg::*;
#(
    parameter int unsigned TAG_W  = 22,
    parameter int unsigned IDX_W  = 5,
    parameter int unsigned LINE_W = 256,
    localparam int unsigned WSEL_W = $clog2(LINE_W / 32)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx,
    output logic [TAG_W-1:0]  tag,
    output logic              valid,
    output logic              dirty,
    output logic [LINE_W-1:0] line,
    input  logic              word_we,
    input  logic [WSEL_W-1:0] word_sel,
    input  logic [31:0]       word_data,
    input  logic [3:0]        word_be,
    input  logic              line_we,
    input  logic [TAG_W-1:0]  line_tag,
    input  logic [LINE_W-1:0] line_data
);
    localparam int unsigned SETS = 2 ** IDX_W;

    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] data_q [SETS];
    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;

    assign tag   = tag_q[idx];
    assign line  = data_q[idx];
    assign valid = valid_q[idx];
    assign dirty = dirty_q[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data contents survive reset; only the state bits above are cleared.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[idx]  <= line_tag;
            data_q[idx] <= line_data;
        end else if (word_we) begin
            data_q[idx][{word_sel, 5'b0} +: 32] <=
                merge_bytes(data_q[idx][{word_sel, 5'b0} +: 32], word_data, word_be);
        end
    end

endmodule

// File: rtl/dcache_2way_top.sv
// 2-way set-associative, write-back, write-allocate L1 data cache with per-set LRU.
// Misses run write-back (if the victim is dirty), allocate, and a one-cycle refill before the hit.
module dcache_2way_top
    import dcache_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned SETS   = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    dcache_2way_top_if.slave    bus
);
    localparam int unsigned OFF_W  = calc_off_w(LINE_W);
    localparam int unsigned IDX_W  = calc_idx_w(SETS);
    localparam int unsigned TAG_W  = calc_tag_w(ADDR_W, LINE_W, SETS);
    localparam int unsigned WSEL_W = OFF_W - 2;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WSEL_W-1:0] word_sel;
    logic              unused_addr;

    assign idx         = bus.p1_addr_i[OFF_W +: IDX_W];
    assign tag         = bus.p1_addr_i[ADDR_W-1 -: TAG_W];
    assign word_sel    = bus.p1_addr_i[2 +: WSEL_W];
    assign unused_addr = ^bus.p1_addr_i[1:0];

    logic [TAG_W-1:0]  way_tag  [2];
    logic [LINE_W-1:0] way_line [2];
    logic [1:0]        way_valid;
    logic [1:0]        way_dirty;
    logic [1:0]        word_we;
    logic [1:0]        line_we;
    logic [1:0]        hit;

    state_t            state_q;
    logic              victim_q;
    logic [SETS-1:0]   lru_q;
    logic              mem_enable_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] mem_data_q;

    logic req, idle, hit_any, hit_way, vic, fill;
    logic [ADDR_W-1:0] line_addr;

    assign req       = bus.p1_MemRead_i | bus.p1_MemWrite_i;
    assign idle      = (state_q == IDLE);
    assign hit_any   = |hit;
    assign hit_way   = hit[1];
    assign vic       = lru_q[idx];
    assign fill      = (state_q == ALLOCATE) & bus.mem_ack_i;
    assign line_addr = {tag, idx, {OFF_W{1'b0}}};

    for (genvar w = 0; w < 2; w++) begin : g_way
        assign hit[w]     = way_valid[w] & (way_tag[w] == tag);
        assign word_we[w] = idle & bus.p1_MemWrite_i & hit[w];

        dcache_way_array #(
            .TAG_W  (TAG_W),
            .IDX_W  (IDX_W),
            .LINE_W (LINE_W)
        ) u_way (
            .clk       (clk_i),
            .rst       (rst_i),
            .idx       (idx),
            .tag       (way_tag[w]),
            .valid     (way_valid[w]),
            .dirty     (way_dirty[w]),
            .line      (way_line[w]),
            .word_we   (word_we[w]),
            .word_sel  (word_sel),
            .word_data (bus.p1_data_i),
            .word_be   (bus.p1_be_i),
            .line_we   (line_we[w]),
            .line_tag  (tag),
            .line_data (bus.mem_data_i)
        );
    end

    assign line_we = fill ? (victim_q ? 2'b10 : 2'b01) : 2'b00;

    // A freshly refilled line already matches in REFILL; it only counts as a hit back in IDLE.
    assign bus.p1_stall_o = req & (~hit_any | ~idle);
    assign bus.p1_data_o  = (bus.p1_MemRead_i & ~bus.p1_MemWrite_i & hit_any & idle)
                          ? way_line[hit_way][{word_sel, 5'b0} +: 32] : '0;

    assign bus.mem_enable_o = mem_enable_q;
    assign bus.mem_write_o  = mem_write_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_data_o   = mem_data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lru_q <= '0;
        end else if (idle & req & hit_any) begin
            lru_q[idx] <= ~hit_way;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            victim_q     <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req & ~hit_any) begin
                        victim_q     <= vic;
                        mem_enable_q <= 1'b1;
                        if (way_valid[vic] & way_dirty[vic]) begin
                            state_q     <= WRITEBACK;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {way_tag[vic], idx, {OFF_W{1'b0}}};
                            mem_data_q  <= way_line[vic];
                        end else begin
                            state_q     <= ALLOCATE;
                            mem_write_q <= 1'b0;
                            mem_addr_q  <= line_addr;
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ack_i) begin
                        state_q     <= ALLOCATE;
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= line_addr;
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ack_i) begin
                        state_q      <= REFILL;
                        mem_enable_q <= 1'b0;
                    end
                end
                REFILL: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
